// File: rtl/adder_multicycle.sv
// adder_multicycle
// Multi-cycle adder/subtractor. A WIDTH-bit operation is processed CHUNK bits
// per cycle, LSB chunk first, with the carry between chunks held in a register.
// Subtraction is computed as a + ~b + ~cin, so carry_out=1 means "no borrow".
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake (accepted only in IDLE)
//   a, b, sub, cin        operands, mode (0 add, 1 subtract), carry/borrow in
//   out_valid / out_ready result handshake (result held until accepted)
//   result                sum/difference mod 2^WIDTH
//   carry_out             raw carry out of the MSB
//   overflow              signed overflow (carry into MSB xor carry out of MSB)
//   zero                  result == 0
module adder_multicycle #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    // Guarded so a bad CHUNK reports the error below instead of dividing by zero.
    localparam int N     = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH ||
            ((CHUNK >= 1) ? (WIDTH % CHUNK) : 1) != 0) begin : g_bad_params
            $error("adder_multicycle: CHUNK must be in 1..WIDTH and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;     // already inverted in subtract mode
    logic               c;       // carry into the chunk being processed
    logic [IDX_W-1:0]   idx;

    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK:0]     sum;
    logic [WIDTH-1:0]   res_next;
    logic               msb_cin;
    logic               last;

    assign a_chunk = a_r[int'(idx)*CHUNK +: CHUNK];
    assign b_chunk = b_r[int'(idx)*CHUNK +: CHUNK];
    assign sum     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c};
    assign last    = (idx == IDX_W'(N - 1));

    // The carry into the top bit of a chunk is recoverable from that bit's
    // sum: s = a ^ b ^ cin  =>  cin = a ^ b ^ s. Valid for CHUNK == 1 too.
    assign msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum[CHUNK-1];

    // Result with the current chunk merged in; zero is taken from this so the
    // final chunk is included in the same cycle it is produced.
    always_comb begin
        res_next = result;
        res_next[int'(idx)*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            c         <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= sub ? ~b : b;
                        c        <= sub ? ~cin : cin;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    result <= res_next;
                    c      <= sum[CHUNK];
                    if (last) begin
                        carry_out <= sum[CHUNK];
                        overflow  <= msb_cin ^ sum[CHUNK];
                        zero      <= (res_next == '0);
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                DONE: begin
                    // Hold result and flags until the consumer takes them.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_multicycle.sv
// Testbench for adder_multicycle. Four instances share one set of inputs:
//   inst0 WIDTH=8  CHUNK=2  (N=4)
//   inst1 WIDTH=8  CHUNK=4  (N=2)
//   inst2 WIDTH=32 CHUNK=32 (N=1)
//   inst3 WIDTH=32 CHUNK=8  (N=4)
// Each operation is started on all of them together; all are released with
// out_ready once every instance has raised out_valid.
module tb_adder_multicycle;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a, b;
    logic        sub, cin;
    logic        out_ready;

    logic [3:0]  in_ready_v, out_valid_v, carry_v, ovf_v, zero_v;
    logic [7:0]  r0, r1;
    logic [31:0] r2, r3;
    logic [31:0] res_v [4];

    always #5 clk = ~clk;

    adder_multicycle #(.WIDTH(8), .CHUNK(2)) u_w8c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .a(a[7:0]), .b(b[7:0]), .sub(sub), .cin(cin),
        .out_valid(out_valid_v[0]), .out_ready(out_ready), .result(r0),
        .carry_out(carry_v[0]), .overflow(ovf_v[0]), .zero(zero_v[0]));

    adder_multicycle #(.WIDTH(8), .CHUNK(4)) u_w8c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .a(a[7:0]), .b(b[7:0]), .sub(sub), .cin(cin),
        .out_valid(out_valid_v[1]), .out_ready(out_ready), .result(r1),
        .carry_out(carry_v[1]), .overflow(ovf_v[1]), .zero(zero_v[1]));

    adder_multicycle #(.WIDTH(32), .CHUNK(32)) u_w32c32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(out_valid_v[2]), .out_ready(out_ready), .result(r2),
        .carry_out(carry_v[2]), .overflow(ovf_v[2]), .zero(zero_v[2]));

    adder_multicycle #(.WIDTH(32), .CHUNK(8)) u_w32c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[3]),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(out_valid_v[3]), .out_ready(out_ready), .result(r3),
        .carry_out(carry_v[3]), .overflow(ovf_v[3]), .zero(zero_v[3]));

    assign res_v[0] = {24'h0, r0};
    assign res_v[1] = {24'h0, r1};
    assign res_v[2] = r2;
    assign res_v[3] = r3;

    int checks = 0;
    int errors = 0;

    int          lat_exp [4] = '{4, 2, 1, 4};
    int          width_v [4] = '{8, 8, 32, 32};
    int          lat     [4];
    logic [31:0] cap_r   [4];
    logic [2:0]  cap_f   [4];

    typedef struct {
        logic        s;
        logic        ci;
        logic [31:0] av;
        logic [31:0] bv;
        logic [7:0]  r8;
        logic [2:0]  f8;   // {carry, overflow, zero}
        logic [31:0] r32;
        logic [2:0]  f32;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %h want %h", nm, inst, act, exp);
        end
    endtask

    // Reference: plain (WIDTH+1)-bit addition; overflow from operand/result signs.
    function automatic logic [34:0] model(input int w, input logic s, input logic ci,
                                          input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] mask, ae, be, res;
        logic [32:0] full;
        logic        c0, co, v, z;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        ae   = av & mask;
        be   = (s ? ~bv : bv) & mask;
        c0   = s ? ~ci : ci;
        full = {1'b0, ae} + {1'b0, be} + {32'h0, c0};
        res  = full[31:0] & mask;
        co   = full[w];
        v    = (ae[w-1] == be[w-1]) && (res[w-1] != ae[w-1]);
        z    = (res == 32'h0);
        return {res, co, v, z};
    endfunction

    // Run one operation on all instances; capture outputs and latency, hold in
    // DONE for 'stall' cycles (checking stability and that inputs are ignored).
    task automatic do_op(input logic s, input logic ci, input logic [31:0] av,
                         input logic [31:0] bv, input int stall);
        logic [3:0] got;
        a = av; b = bv; sub = s; cin = ci; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~av; b = 32'h5A5A_5A5A; // stale data must not matter once latched
        got = 4'h0;
        for (int k = 0; k < 4; k++) lat[k] = 0;
        for (int cyc = 1; cyc <= 16 && got != 4'hF; cyc++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                if (out_valid_v[k] && !got[k]) begin
                    got[k]   = 1'b1;
                    lat[k]   = cyc;
                    cap_r[k] = res_v[k];
                    cap_f[k] = {carry_v[k], ovf_v[k], zero_v[k]};
                end
            end
            chk("valid_and_ready", -1, {28'h0, out_valid_v & in_ready_v}, 32'h0);
        end
        chk("timeout", -1, {28'h0, got}, 32'hF);
        for (int st = 0; st < stall; st++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom; sub = ~s;
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                chk("hold_result", k, res_v[k], cap_r[k]);
                chk("hold_flags", k, {29'h0, carry_v[k], ovf_v[k], zero_v[k]},
                    {29'h0, cap_f[k]});
            end
            chk("hold_in_ready", -1, {28'h0, in_ready_v}, 32'h0);
            chk("hold_out_valid", -1, {28'h0, out_valid_v}, 32'hF);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_in_ready", -1, {28'h0, in_ready_v}, 32'hF);
        chk("release_out_valid", -1, {28'h0, out_valid_v}, 32'h0);
    endtask

    task automatic check_op(input logic [31:0] er [4], input logic [2:0] ef [4]);
        for (int k = 0; k < 4; k++) begin
            chk("result", k, cap_r[k], er[k]);
            chk("flags_cvz", k, {29'h0, cap_f[k]}, {29'h0, ef[k]});
            chk("latency", k, lat[k], lat_exp[k]);
        end
    endtask

    initial begin
        logic [31:0] er [4];
        logic [2:0]  ef [4];
        logic [34:0] m;
        logic        rs, rc;
        logic [31:0] ra, rb;

        //            sub ci  a             b             r8     cvz     r32           cvz
        tbl[0] = '{1'b0, 1'b0, 32'h0000_007F, 32'h0000_0001, 8'h80, 3'b010, 32'h0000_0080, 3'b000};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0005, 8'h00, 3'b101, 32'h0000_0000, 3'b101};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0001, 8'hFF, 3'b000, 32'hFFFF_FFFF, 3'b000};
        tbl[3] = '{1'b0, 1'b1, 32'h0000_00FF, 32'h0000_0000, 8'h00, 3'b101, 32'h0000_0100, 3'b000};
        tbl[4] = '{1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 8'h00, 3'b101, 32'h8000_0000, 3'b010};
        tbl[5] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 8'hFF, 3'b000, 32'h7FFF_FFFF, 3'b110};
        tbl[6] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_0005, 8'h0A, 3'b100, 32'h0000_000A, 3'b100};
        tbl[7] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'hFF, 3'b100, 32'hFFFF_FFFF, 3'b100};
        tbl[8] = '{1'b0, 1'b0, 32'h0000_0080, 32'h0000_0080, 8'h00, 3'b111, 32'h0000_0100, 3'b000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst_in_ready", -1, {28'h0, in_ready_v}, 32'hF);
        chk("rst_out_valid", -1, {28'h0, out_valid_v}, 32'h0);
        chk("rst_flags", -1, {20'h0, carry_v, ovf_v, zero_v}, 32'h0);
        for (int k = 0; k < 4; k++) chk("rst_result", k, res_v[k], 32'h0);

        // Directed table; stall count varies so backpressure (incl. 3 cycles) is covered
        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].s, tbl[i].ci, tbl[i].av, tbl[i].bv, i % 4);
            er[0] = {24'h0, tbl[i].r8}; er[1] = {24'h0, tbl[i].r8};
            er[2] = tbl[i].r32;         er[3] = tbl[i].r32;
            ef[0] = tbl[i].f8;  ef[1] = tbl[i].f8;
            ef[2] = tbl[i].f32; ef[3] = tbl[i].f32;
            check_op(er, ef);
        end

        // Reset on the 2nd RUN cycle, after a chunk that produced a carry
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_in_ready", -1, {28'h0, in_ready_v}, 32'hF);
        chk("abort_out_valid", -1, {28'h0, out_valid_v}, 32'h0);
        chk("abort_flags", -1, {20'h0, carry_v, ovf_v, zero_v}, 32'h0);
        for (int k = 0; k < 4; k++) chk("abort_result", k, res_v[k], 32'h0);
        do_op(1'b0, 1'b0, 32'h0000_0012, 32'h0000_0034, 0);
        for (int k = 0; k < 4; k++) begin er[k] = 32'h0000_0046; ef[k] = 3'b000; end
        check_op(er, ef);

        // Random operations against the reference model
        for (int i = 0; i < 1000; i++) begin
            rs = 1'(($urandom_range(0, 1)));
            rc = 1'(($urandom_range(0, 1)));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = ra;
                1:       rb = ~ra;
                2:       rb = 32'h0;
                default: rb = $urandom;
            endcase
            do_op(rs, rc, ra, rb, int'($urandom_range(0, 3)));
            for (int k = 0; k < 4; k++) begin
                m     = model(width_v[k], rs, rc, ra, rb);
                er[k] = m[34:3];
                ef[k] = m[2:0];
            end
            check_op(er, ef);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
